// File: rtl/microsequencer_if.sv
// microsequencer_if: signal bundle between the microsequencer and its environment.
//   Inputs to the sequencer:
//     Tipo     next-address type code from the branch-condition logic
//     JumpAddr MIR jump address field
//     IR       current instruction register
//     MemReq   current microinstruction issues a RD or WR
//     MemReady memory completion (level)
//   Outputs from the sequencer:
//     Addr     registered control-store address
//     Stall    current microinstruction is being held (combinational)
//     Timeout  sticky memory-timeout flag
// Modports:
//   master : environment side (drives the inputs, observes the outputs)
//   slave  : sequencer side
interface microsequencer_if #(
    parameter int MICROSEQUENCER_ADDR = 11,
    parameter int MICROSEQUENCER_TIPO = 2,
    parameter int MICROSEQUENCER_IR   = 32
);
    logic [MICROSEQUENCER_TIPO-1:0] MICROSEQUENCER_Tipo_InBus;
    logic [MICROSEQUENCER_ADDR-1:0] MICROSEQUENCER_JumpAddr_InBus;
    logic [MICROSEQUENCER_IR-1:0]   MICROSEQUENCER_IR_InBus;
    logic                           MICROSEQUENCER_MemReq_In;
    logic                           MICROSEQUENCER_MemReady_In;
    logic [MICROSEQUENCER_ADDR-1:0] MICROSEQUENCER_Addr_OutBus;
    logic                           MICROSEQUENCER_Stall_Out;
    logic                           MICROSEQUENCER_Timeout_Out;

    modport master (
        output MICROSEQUENCER_Tipo_InBus, MICROSEQUENCER_JumpAddr_InBus,
               MICROSEQUENCER_IR_InBus, MICROSEQUENCER_MemReq_In,
               MICROSEQUENCER_MemReady_In,
        input  MICROSEQUENCER_Addr_OutBus, MICROSEQUENCER_Stall_Out,
               MICROSEQUENCER_Timeout_Out
    );

    modport slave (
        input  MICROSEQUENCER_Tipo_InBus, MICROSEQUENCER_JumpAddr_InBus,
               MICROSEQUENCER_IR_InBus, MICROSEQUENCER_MemReq_In,
               MICROSEQUENCER_MemReady_In,
        output MICROSEQUENCER_Addr_OutBus, MICROSEQUENCER_Stall_Out,
               MICROSEQUENCER_Timeout_Out
    );
endinterface

// File: rtl/microsequencer.sv
// microsequencer: control-store address sequencer.
//   Selects the next microinstruction address (NEXT / JUMP / DECODE / HOLD),
//   stretches memory-access microinstructions until MemReady, and forces
//   TRAP_ADDR with a sticky Timeout flag when memory stays silent for
//   TIMEOUT wait cycles.
// Ports:
//   MICROSEQUENCER_CLOCK_50        system clock, rising edge
//   MICROSEQUENCER_ResetInHigh_In  synchronous active-high reset
//   bus                            microsequencer_if.slave (see interface header)
module microsequencer #(
    parameter int                             MICROSEQUENCER_ADDR      = 11,
    parameter int                             MICROSEQUENCER_TIPO      = 2,
    parameter int                             MICROSEQUENCER_IR        = 32,
    parameter int                             MICROSEQUENCER_TIMEOUT   = 16,
    parameter logic [MICROSEQUENCER_ADDR-1:0] MICROSEQUENCER_TRAP_ADDR = 11'h7F0
) (
    input  logic                  MICROSEQUENCER_CLOCK_50,
    input  logic                  MICROSEQUENCER_ResetInHigh_In,
    microsequencer_if.slave       bus
);
    localparam int AW = MICROSEQUENCER_ADDR;
    localparam int CW = $clog2(MICROSEQUENCER_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(MICROSEQUENCER_TIMEOUT - 1);

    typedef enum logic {RUN, WAIT} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW-1:0]   pend_q, pend_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tout_q, tout_d;
    logic [AW-1:0]   sel_addr;
    logic            mem_wait;

    // IR fields outside the decode slice are intentionally ignored.
    logic unused_ir;
    assign unused_ir = ^{bus.MICROSEQUENCER_IR_InBus[29:25], bus.MICROSEQUENCER_IR_InBus[18:0]};

    // Next-address selection from the type code.
    always_comb begin
        sel_addr = addr_q;
        case (bus.MICROSEQUENCER_Tipo_InBus)
            2'b00:   sel_addr = addr_q + AW'(1);
            2'b01:   sel_addr = bus.MICROSEQUENCER_JumpAddr_InBus;
            2'b10:   sel_addr = AW'({1'b1, bus.MICROSEQUENCER_IR_InBus[31:30],
                                     bus.MICROSEQUENCER_IR_InBus[24:19], 2'b00});
            default: sel_addr = addr_q;
        endcase
    end

    assign mem_wait = bus.MICROSEQUENCER_MemReq_In & ~bus.MICROSEQUENCER_MemReady_In;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        tout_d  = tout_q;
        case (state_q)
            RUN: begin
                if (mem_wait) begin
                    pend_d  = sel_addr;
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    addr_d = sel_addr;
                end
            end
            WAIT: begin
                // Ready beats the trap when both land on the same cycle.
                if (bus.MICROSEQUENCER_MemReady_In) begin
                    addr_d  = pend_q;
                    state_d = RUN;
                end else if (cnt_q == CNT_LAST) begin
                    addr_d  = MICROSEQUENCER_TRAP_ADDR;
                    tout_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge MICROSEQUENCER_CLOCK_50) begin
        if (MICROSEQUENCER_ResetInHigh_In) begin
            state_q <= RUN;
            addr_q  <= '0;
            pend_q  <= '0;
            cnt_q   <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            tout_q  <= tout_d;
        end
    end

    // Combinational so the datapath can gate its writes in the request cycle.
    assign bus.MICROSEQUENCER_Stall_Out   = (state_q == WAIT) | ((state_q == RUN) & mem_wait);
    assign bus.MICROSEQUENCER_Addr_OutBus = addr_q;
    assign bus.MICROSEQUENCER_Timeout_Out = tout_q;
endmodule
